// File: rtl/generador_phy_tx.sv
// rtl/generador_phy_tx.sv - multi-lane PHY transmit generator: COM sync burst, then framed lane data serialized MSB first
module generador_phy_tx #(
    parameter int               LANES      = 4,
    parameter int               WIDTH      = 8,
    parameter int               SYNC_COUNT = 4,
    parameter logic [WIDTH-1:0] COM        = 8'hBC,
    parameter logic [WIDTH-1:0] IDLE       = 8'h7C,
    parameter logic [WIDTH-1:0] STEP       = 8'h11
) (
    input  logic                     clk_32f,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [LANES-1:0]         lane_mask,
    input  logic                     gap_mode,
    output logic [LANES*WIDTH-1:0]   data_out,
    output logic [LANES-1:0]         valid_out,
    output logic                     serial_out,
    output logic                     frame_start,
    output logic                     sync_done
);

    localparam int BIT_W    = $clog2(WIDTH);
    localparam int LANE_W   = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int SYNC_LEN = SYNC_COUNT * WIDTH;
    localparam int SYNC_W   = (SYNC_LEN > 1) ? $clog2(SYNC_LEN) : 1;

    localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_LEN - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(LANES - 1);

    typedef enum logic {
        S_SYNC = 1'b0,
        S_DATA = 1'b1
    } state_t;

    state_t               state;
    state_t               state_nxt;

    logic [SYNC_W-1:0]    sync_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [LANE_W-1:0]    lane_cnt;
    logic [WIDTH-1:0]     frame_cnt;
    logic                 gap_flag;

    logic                 frame_first;
    logic                 is_data;
    logic [WIDTH-1:0]     acc;
    logic [LANES*WIDTH-1:0] data_load;
    logic [LANES*WIDTH-1:0] data_now;
    logic [LANES-1:0]     valid_now;
    logic [WIDTH-1:0]     word_sel;
    logic                 ser_bit;

    // State register: reset always returns to the full sync burst
    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            state <= S_SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: leave SYNC after the last COM bit goes out; DATA holds until reset
    always_comb begin
        state_nxt = state;
        case (state)
            S_SYNC: begin
                if (sync_cnt == SYNC_LAST) begin
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                state_nxt = S_DATA;
            end
            default: begin
                state_nxt = S_SYNC;
            end
        endcase
    end

    // Payload words for a data frame: lane i carries frame_cnt + i*STEP, zero when masked off
    always_comb begin
        acc       = frame_cnt;
        data_load = '0;
        for (int i = 0; i < LANES; i++) begin
            if (lane_mask[i]) begin
                data_load[i*WIDTH +: WIDTH] = acc;
            end
            acc = acc + STEP;
        end
    end

    // Frame decode and serial bit select; on the first frame cycle the freshly loaded words are used
    always_comb begin
        frame_first = (state == S_DATA) && (bit_cnt == '0) && (lane_cnt == '0);
        is_data     = enable && !gap_flag;
        valid_now   = valid_out;
        data_now    = data_out;
        if (frame_first) begin
            valid_now = is_data ? lane_mask : '0;
            if (is_data) begin
                data_now = data_load;
            end
        end
        word_sel = IDLE;
        for (int i = 0; i < LANES; i++) begin
            if ((LANE_W'(i) == lane_cnt) && valid_now[i]) begin
                word_sel = data_now[i*WIDTH +: WIDTH];
            end
        end
        ser_bit = word_sel[~bit_cnt];
    end

    // Counters, frame bookkeeping and all registered outputs
    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            sync_cnt    <= '0;
            bit_cnt     <= '0;
            lane_cnt    <= '0;
            frame_cnt   <= '0;
            gap_flag    <= 1'b0;
            data_out    <= '0;
            valid_out   <= '0;
            serial_out  <= 1'b0;
            frame_start <= 1'b0;
            sync_done   <= 1'b0;
        end else begin
            case (state)
                S_SYNC: begin
                    serial_out  <= COM[~sync_cnt[BIT_W-1:0]];
                    sync_cnt    <= (sync_cnt == SYNC_LAST) ? '0 : sync_cnt + 1'b1;
                    bit_cnt     <= '0;
                    lane_cnt    <= '0;
                    data_out    <= '0;
                    valid_out   <= '0;
                    frame_start <= 1'b0;
                    sync_done   <= 1'b0;
                end
                S_DATA: begin
                    sync_done   <= 1'b1;
                    serial_out  <= ser_bit;
                    frame_start <= frame_first;
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt  <= '0;
                        lane_cnt <= (lane_cnt == LANE_LAST) ? '0 : lane_cnt + 1'b1;
                    end else begin
                        bit_cnt  <= bit_cnt + 1'b1;
                    end
                    // Frame type, payload and gap decision are latched once per frame
                    if (frame_first) begin
                        valid_out <= valid_now;
                        data_out  <= data_now;
                        gap_flag  <= is_data && gap_mode;
                        if (is_data) begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    serial_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_generador_phy_tx.sv
// tb/tb_generador_phy_tx.sv - frame-table scoreboard bench for generador_phy_tx
module tb_generador_phy_tx;

    logic        clk_32f   = 1'b0;
    logic        reset     = 1'b0;
    logic        enable    = 1'b0;
    logic        gap_mode  = 1'b0;
    logic [3:0]  lane_mask = 4'h0;
    logic [31:0] data_out;
    logic [3:0]  valid_out;
    logic        serial_out;
    logic        frame_start;
    logic        sync_done;

    always #5 clk_32f = ~clk_32f;

    generador_phy_tx #(
        .LANES(4), .WIDTH(8), .SYNC_COUNT(4),
        .COM(8'hBC), .IDLE(8'h7C), .STEP(8'h11)
    ) dut (
        .clk_32f(clk_32f),
        .reset(reset),
        .enable(enable),
        .lane_mask(lane_mask),
        .gap_mode(gap_mode),
        .data_out(data_out),
        .valid_out(valid_out),
        .serial_out(serial_out),
        .frame_start(frame_start),
        .sync_done(sync_done)
    );

    typedef struct {
        logic        en;
        logic [3:0]  mask;
        logic        gap;
        logic        scr;
        logic [31:0] d;
        logic [3:0]  v;
        logic [31:0] s;
    } vec_t;

    vec_t vecs [14];
    vec_t last_vec;
    vec_t sb [$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        enable    = v.en;
        lane_mask = v.mask;
        gap_mode  = v.gap;
        sb.push_back(v);
    endtask

    task automatic sync_phase(input string tag, input vec_t first);
        logic [31:0] s = '0;
        int          flag_err = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk_32f);
            s = {s[30:0], serial_out};
            if (sync_done !== 1'b0 || frame_start !== 1'b0 || valid_out !== 4'h0 || data_out !== 32'h0)
                flag_err++;
            if (i == 20) drive(first);
        end
        chk({tag, " serial"}, s, 32'hBCBCBCBC);
        chk({tag, " flags"}, 32'(flag_err), 32'h0);
        @(negedge clk_32f);
        chk({tag, " sync_done"}, {31'h0, sync_done}, 32'h1);
    endtask

    task automatic run_frame(input string tag, input bit scr, input bit have_nxt, input vec_t nxt);
        logic [31:0] d0 = '0;
        logic [31:0] s  = '0;
        logic [3:0]  v0 = '0;
        int          hold_err = 0;
        int          fs_err   = 0;
        vec_t        e;
        for (int i = 0; i < 32; i++) begin
            if (i > 0) @(negedge clk_32f);
            if (i == 0) begin
                d0 = data_out;
                v0 = valid_out;
                if (frame_start !== 1'b1) fs_err++;
            end else begin
                if (frame_start !== 1'b0) fs_err++;
                if (data_out !== d0 || valid_out !== v0) hold_err++;
            end
            s = {s[30:0], serial_out};
            if (scr && i == 10) begin
                enable    = 1'b0;
                lane_mask = ~lane_mask;
                gap_mode  = 1'b1;
            end
            if (have_nxt && i == 31) drive(nxt);
        end
        @(negedge clk_32f);
        if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s scoreboard: got empty queue expected entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, " data"}, d0, e.d);
            chk({tag, " valid"}, {28'h0, v0}, {28'h0, e.v});
            chk({tag, " serial"}, s, e.s);
            chk({tag, " frame_start"}, 32'(fs_err), 32'h0);
            chk({tag, " hold"}, 32'(hold_err), 32'h0);
        end
    endtask

    initial begin
        vec_t e;
        logic [31:0] s;
        //        en    mask  gap   scr   data_out       valid  serial
        vecs[0]  = '{1'b1, 4'hF, 1'b0, 1'b0, 32'h33221100, 4'hF, 32'h00112233};
        vecs[1]  = '{1'b1, 4'hF, 1'b0, 1'b1, 32'h34231201, 4'hF, 32'h01122334};
        vecs[2]  = '{1'b1, 4'h5, 1'b0, 1'b0, 32'h00240002, 4'h5, 32'h027C247C};
        vecs[3]  = '{1'b1, 4'hF, 1'b0, 1'b1, 32'h36251403, 4'hF, 32'h03142536};
        vecs[4]  = '{1'b0, 4'hF, 1'b0, 1'b0, 32'h36251403, 4'h0, 32'h7C7C7C7C};
        vecs[5]  = '{1'b0, 4'hF, 1'b0, 1'b0, 32'h36251403, 4'h0, 32'h7C7C7C7C};
        vecs[6]  = '{1'b1, 4'hF, 1'b0, 1'b0, 32'h37261504, 4'hF, 32'h04152637};
        vecs[7]  = '{1'b1, 4'hF, 1'b1, 1'b0, 32'h38271605, 4'hF, 32'h05162738};
        vecs[8]  = '{1'b1, 4'hF, 1'b1, 1'b0, 32'h38271605, 4'h0, 32'h7C7C7C7C};
        vecs[9]  = '{1'b1, 4'hF, 1'b1, 1'b0, 32'h39281706, 4'hF, 32'h06172839};
        vecs[10] = '{1'b1, 4'hF, 1'b0, 1'b0, 32'h39281706, 4'h0, 32'h7C7C7C7C};
        vecs[11] = '{1'b1, 4'hA, 1'b0, 1'b0, 32'h3A001800, 4'hA, 32'h7C187C3A};
        vecs[12] = '{1'b1, 4'h0, 1'b0, 1'b0, 32'h00000000, 4'h0, 32'h7C7C7C7C};
        vecs[13] = '{1'b1, 4'hF, 1'b0, 1'b0, 32'h3C2B1A09, 4'hF, 32'h091A2B3C};
        last_vec = '{1'b1, 4'hF, 1'b0, 1'b0, 32'h3D2C1B0A, 4'hF, 32'h0A1B2C3D};

        reset = 1'b0;
        repeat (3) @(negedge clk_32f);
        chk("reset data", data_out, 32'h0);
        chk("reset valid", {28'h0, valid_out}, 32'h0);
        chk("reset flags", {29'h0, serial_out, frame_start, sync_done}, 32'h0);

        reset = 1'b1;
        sync_phase("sync", vecs[0]);

        for (int k = 0; k < 14; k++) begin
            run_frame($sformatf("f%0d", k), vecs[k].scr, 1'b1, (k < 13) ? vecs[k + 1] : last_vec);
        end

        // Abort a data frame at its tenth cycle, then expect a fresh sync and frame_cnt back at 0
        if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL f14 scoreboard: got empty queue expected entry");
        end else begin
            e = sb.pop_front();
            chk("f14 data", data_out, e.d);
        end
        repeat (9) @(negedge clk_32f);
        reset = 1'b0;
        @(negedge clk_32f);
        chk("midreset data", data_out, 32'h0);
        chk("midreset valid", {28'h0, valid_out}, 32'h0);
        chk("midreset flags", {29'h0, serial_out, frame_start, sync_done}, 32'h0);
        reset = 1'b1;
        sync_phase("resync", vecs[0]);
        run_frame("post_reset", 1'b0, 1'b0, vecs[0]);

        s = 32'(sb.size());
        chk("scoreboard drained", s, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
